// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues 1-cycle-latency word reads and buffers
// returned words in a small FIFO presented to decode with a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q;
  logic [31:0]     inflight_pc_q;
  logic            outstanding_q;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     last_instr_q;
  logic [31:0]     last_pc_q;

  logic            empty;
  logic            pop;
  logic            push;
  logic [CntW:0]   slots_used;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    empty       = (count_q == '0);
    instr_valid = !empty;
    pop         = instr_valid && instr_ready;
    // A response landing in a redirect cycle is wrong-path and is dropped with the flush.
    push        = imem_valid && outstanding_q && !redirect;
    // Occupancy plus the in-flight word, with a same-cycle pop already freeing its slot.
    slots_used  = {1'b0, count_q} + {{CntW{1'b0}}, outstanding_q} - {{CntW{1'b0}}, pop};
    imem_req    = !redirect && (slots_used < (CntW + 1)'(DEPTH));
    imem_addr   = fetch_pc_q[ADDR_W+1:2];
    instr       = empty ? last_instr_q : data_q[rptr_q];
    instr_pc    = empty ? last_pc_q : pc_q[rptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      outstanding_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (pop) begin
        last_instr_q <= instr;
        last_pc_q    <= instr_pc;
      end
      if (redirect) begin
        fetch_pc_q    <= {redirect_pc[31:2], 2'b00};
        outstanding_q <= 1'b0;
        wptr_q        <= '0;
        rptr_q        <= '0;
        count_q       <= '0;
      end else begin
        if (imem_req) begin
          inflight_pc_q <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + 32'd4;
          outstanding_q <= 1'b1;
        end else if (push) begin
          outstanding_q <= 1'b0;
        end
        if (push) begin
          data_q[wptr_q] <= imem_rdata;
          pc_q[wptr_q]   <= inflight_pc_q;
          wptr_q         <= wptr_q + 1'b1;
        end
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
        count_q <= count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: a 1-cycle memory model feeds the DUT and a scoreboard
// of expected PCs (sequential from reset or the last redirect) is checked at every handshake.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              stray;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  // Memory: word at address a is 0x1000_0000 + a; stray forces an unsolicited response.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
  end
  always @(posedge clk) begin
    imem_valid <= imem_req || stray;
    imem_rdata <= stray ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc / 4) % 1024);
  endfunction

  // Scoreboard: queue of expected PCs, restarted at reset and at every redirect.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic        red_prev;
  logic        stall_prev;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      gen_pc     = RESET_PC;
      red_prev   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (red_prev) check("valid_after_redirect", instr_valid, 1'b0);
      if (stall_prev) begin
        check("stall_valid", instr_valid, 1'b1);
        check("stall_instr", instr, prev_instr);
        check("stall_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        logic [31:0] p;
        while (exp_q.size() < 4) begin
          exp_q.push_back(gen_pc);
          gen_pc = gen_pc + 32'd4;
        end
        p = exp_q.pop_front();
        check("deliver_pc", instr_pc, p);
        check("deliver_instr", instr, word_at(p));
      end
      if (redirect) begin
        exp_q.delete();
        gen_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      red_prev   = redirect;
      stall_prev = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (instr_valid) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(posedge clk);
    #1 redirect = 1'b0;
  endtask

  // After reset release at the last posedge: cycles 1..3 of the fetch start-up.
  task automatic check_startup();
    @(negedge clk);
    check("c1_req", imem_req, 1'b1);
    check("c1_addr", 32'(imem_addr), 32'd1022);
    check("c1_valid", instr_valid, 1'b0);
    check("c1_instr", instr, 32'd0);
    check("c1_pc", instr_pc, 32'd0);
    @(negedge clk);
    check("c2_valid", instr_valid, 1'b0);
    check("c2_addr", 32'(imem_addr), 32'd1023);
    @(negedge clk);
    check("c3_valid", instr_valid, 1'b1);
    check("c3_pc", instr_pc, 32'hFFFF_FFF8);
    check("c3_addr", 32'(imem_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stray       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_startup();

    repeat (6) begin
      @(negedge clk);
      check("throughput", instr_valid, 1'b1);
    end

    // Back-pressure fills the FIFO and stops requests.
    @(posedge clk);
    #1 instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("full_no_req", imem_req, 1'b0);
    check("full_valid", instr_valid, 1'b1);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("drain_no_gap", instr_valid, 1'b1);
    end

    // Redirect with no handshake; low bits of the target are ignored.
    @(posedge clk);
    #1 instr_ready = 1'b0;
    pulse_redirect(32'h0000_0103);
    instr_ready = 1'b1;
    @(negedge clk);
    check("redir_req", imem_req, 1'b1);
    check("redir_addr", 32'(imem_addr), 32'd64);
    wait_valid("redir_timeout");
    check("redir_target_pc", instr_pc, 32'h0000_0100);

    // Redirect coinciding with a handshake.
    wait_valid("hs_timeout");
    pulse_redirect(32'h0000_0200);
    wait_valid("hs_redir_timeout");
    check("hs_target_pc", instr_pc, 32'h0000_0200);

    // Back-to-back redirects: the last one wins.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    @(posedge clk);
    #1 pulse_redirect(32'h0000_0404);
    wait_valid("b2b_timeout");
    check("b2b_target_pc", instr_pc, 32'h0000_0404);

    // Random back-pressure and redirects.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      instr_ready = ($urandom % 4) != 0;
      redirect    = ($urandom % 16) == 0;
      redirect_pc = (($urandom % 8) == 0) ? 32'hFFFF_FFF4 + ($urandom % 4)
                                          : $urandom & 32'h0000_0FFF;
    end
    @(posedge clk);
    #1 redirect = 1'b0;
    instr_ready = 1'b1;

    // Reset with FIFO occupied and a request in flight, then a stray response after release.
    wait_valid("pre_reset_timeout");
    @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    stray = 1'b1;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    stray       = 1'b0;
    instr_ready = 1'b1;
    check_startup();
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the instruction-word interface consumed by the decode controller.
- Holds the fetch PC and issues word reads to instruction memory (fixed 1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (jump/branch/jr target) from execute; a redirect flushes all wrong-path words.

Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- RESET_PC, 32'h0000_0000: fetch PC after reset. Must be word aligned.
- DEPTH, 2: FIFO entries, power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address = fetch_pc[ADDR_W+1:2].
- imem_rdata  in  32  read data.
- imem_valid  in  1  imem_rdata valid; asserted exactly one cycle after imem_req.
- instr  out  32  instruction word to decode.
- instr_pc  out  32  byte PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts when instr_valid && instr_ready.
- redirect  in  1  one-cycle pulse: discard wrong-path state, refetch.
- redirect_pc  in  32  target byte PC; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, no request outstanding. imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Issue rule: imem_req=1 when !redirect && (occupancy + outstanding) < DEPTH. outstanding is 0 or 1. A pop in the same cycle counts as freeing a slot.
- On issue: record fetch_pc as the in-flight PC; fetch_pc <= fetch_pc+4. Increment wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- On imem_valid with an outstanding request: push {imem_rdata, in-flight PC} into the FIFO and clear outstanding.
- imem_valid with nothing outstanding: ignored. This covers a stale response after reset or after a flush.
- Head of FIFO drives instr/instr_pc; instr_valid = !empty.
- Outputs hold stable while instr_valid && !instr_ready.
- Pop on handshake. Push and pop in the same cycle are both performed; occupancy is unchanged.
- When empty, instr and instr_pc hold their last values and instr_valid=0.
- No combinational path from imem_rdata to instr. First instr_valid occurs 2 cycles after the first request, i.e. cycle 3 after reset release.
- Steady state with instr_ready=1: one instruction per cycle.
- Redirect cycle:
  - FIFO cleared.
  - Outstanding cleared, so the response arriving next cycle is dropped.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - imem_req=0 in the redirect cycle; the first target request issues the following cycle.
  - A handshake in the redirect cycle still completes (that word was consumed), then the flush applies.
  - instr_valid=0 from the cycle after the redirect until the target word arrives.
- Back-to-back redirects: the last one wins; each flushes.
- Full FIFO with instr_ready=0: no requests. The outstanding word still lands because the issue rule reserved its slot; no overflow and no data loss.
- Reset mid-operation: all state returns to reset values immediately.

Test Plan:
- Reset release, instr_ready=1, IMEM word i = 32'h1000_0000+i -> imem_addr 0,1,2,...; instr 32'h1000_0000 at instr_pc 0 on cycle 3, then one word per cycle, instr_pc +4 each.
- Hold instr_ready=0 for 5 cycles -> occupancy reaches DEPTH=2, imem_req=0, instr stays 32'h1000_0000. Release -> words 0,1,2 delivered in order with no gaps.
- Pulse redirect, redirect_pc=32'h0000_0103, mid-stream -> in-flight word dropped; next delivered instr_pc=32'h0000_0100 (word addr 64); no stale word appears.
- Redirect and handshake in the same cycle -> the accepted word counts as delivered exactly once; the next word is the target.
- RESET_PC=32'hFFFF_FFF8 with ADDR_W=10 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr 1022, 1023, 0.
- Assert rst_n=0 with FIFO full and a request outstanding, stray imem_valid=1 on the first post-reset cycle -> instr_valid stays 0; first delivered word is RESET_PC.
